// File: rtl/architecture_pkg.sv
// Shared ISA definitions for the computer: field widths, opcodes, register
// indices, memory size and instruction builders used to assemble programs.
package architecture;

   localparam int INST_WIDTH       = 16;
   localparam int OPCODE_WIDTH     = 4;
   localparam int REG_INDEX_WIDTH  = 3;
   localparam int REG_COUNT        = 8;
   localparam int IMM_WIDTH        = 8;
   localparam int OFFSET_WIDTH     = 9;
   localparam int DATA_WIDTH       = 32;
   localparam int PROG_MEMORY_SIZE = 1024;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_LOADC = 4'h1;
   localparam logic [3:0] OP_ADD   = 4'h2;
   localparam logic [3:0] OP_SUB   = 4'h3;
   localparam logic [3:0] OP_AND   = 4'h4;
   localparam logic [3:0] OP_OR    = 4'h5;
   localparam logic [3:0] OP_XOR   = 4'h6;
   localparam logic [3:0] OP_JMP   = 4'h7;
   localparam logic [3:0] OP_JMPZ  = 4'h8;
   localparam logic [3:0] OP_HALT  = 4'hF;

   localparam logic [2:0] R0 = 3'd0;
   localparam logic [2:0] R1 = 3'd1;
   localparam logic [2:0] R2 = 3'd2;
   localparam logic [2:0] R3 = 3'd3;
   localparam logic [2:0] R4 = 3'd4;
   localparam logic [2:0] R5 = 3'd5;
   localparam logic [2:0] R6 = 3'd6;
   localparam logic [2:0] R7 = 3'd7;

   localparam logic [15:0] NOP_INST  = 16'h0000;
   localparam logic [15:0] HALT_INST = 16'hF000;

   // LOADC: opcode | unused | dest | imm8
   function automatic logic [15:0] loadc_inst(input logic [2:0] dest, input logic [7:0] imm8);
      return {OP_LOADC, 1'b0, dest, imm8};
   endfunction

   // ALU ops: opcode | unused | dest | srcA | srcB
   function automatic logic [15:0] alu_inst(input logic [3:0] op, input logic [2:0] dest,
                                            input logic [2:0] src_a, input logic [2:0] src_b);
      return {op, 3'b000, dest, src_a, src_b};
   endfunction

   function automatic logic [15:0] add_inst(input logic [2:0] dest, input logic [2:0] src_a, input logic [2:0] src_b);
      return alu_inst(OP_ADD, dest, src_a, src_b);
   endfunction

   function automatic logic [15:0] sub_inst(input logic [2:0] dest, input logic [2:0] src_a, input logic [2:0] src_b);
      return alu_inst(OP_SUB, dest, src_a, src_b);
   endfunction

   function automatic logic [15:0] and_inst(input logic [2:0] dest, input logic [2:0] src_a, input logic [2:0] src_b);
      return alu_inst(OP_AND, dest, src_a, src_b);
   endfunction

   function automatic logic [15:0] or_inst(input logic [2:0] dest, input logic [2:0] src_a, input logic [2:0] src_b);
      return alu_inst(OP_OR, dest, src_a, src_b);
   endfunction

   function automatic logic [15:0] xor_inst(input logic [2:0] dest, input logic [2:0] src_a, input logic [2:0] src_b);
      return alu_inst(OP_XOR, dest, src_a, src_b);
   endfunction

   // JMP: opcode | unused | signed offset9
   function automatic logic [15:0] jmp_inst(input logic [8:0] offset);
      return {OP_JMP, 3'b000, offset};
   endfunction

   // JMPZ: opcode | tested reg | signed offset9
   function automatic logic [15:0] jmpz_inst(input logic [2:0] test_reg, input logic [8:0] offset);
      return {OP_JMPZ, test_reg, offset};
   endfunction

endpackage

// File: rtl/program_memory.sv
// Read-only instruction store. Contents are preloaded from outside before the
// processor is released from reset; there is no write path and reset leaves
// the words untouched.
module program_memory
   import architecture::*;
#(
   parameter int SIZE       = PROG_MEMORY_SIZE,
   parameter int ADDR_WIDTH = $clog2(SIZE)
) (
   input  logic [ADDR_WIDTH-1:0] address,
   output logic [INST_WIDTH-1:0] instruction
);

   logic [INST_WIDTH-1:0] memory [0:SIZE-1];

   // Asynchronous fetch so an instruction executes in the cycle it is addressed.
   assign instruction = memory[address];

endmodule

// File: rtl/computer.sv
// Single-cycle processor: fetch, decode, execute and writeback all happen in
// one clock. Eight general-purpose registers, 16-bit instructions, relative
// jumps, and a sticky halt that only reset clears.
module computer #(
   parameter int PROG_MEMORY_SIZE = architecture::PROG_MEMORY_SIZE,
   parameter int DATA_WIDTH       = architecture::DATA_WIDTH
) (
   input logic clock,
   input logic reset
);

   localparam int PC_WIDTH   = $clog2(PROG_MEMORY_SIZE);
   // Wide enough to hold pc + offset9 without overflow, plus a sign bit.
   localparam int JUMP_WIDTH = ((PC_WIDTH > architecture::OFFSET_WIDTH) ?
                                PC_WIDTH : architecture::OFFSET_WIDTH) + 2;

   logic [PC_WIDTH-1:0]          pc;
   logic [PC_WIDTH-1:0]          pc_next;
   logic [PC_WIDTH-1:0]          pc_step;
   logic [PC_WIDTH-1:0]          pc_jump;
   logic                         halted;
   logic                         halt_now;
   logic [DATA_WIDTH-1:0]        registers [0:7];
   logic [15:0]                  instruction;
   logic [3:0]                   opcode;
   logic [DATA_WIDTH-1:0]        operand_a;
   logic [DATA_WIDTH-1:0]        operand_b;
   logic [DATA_WIDTH-1:0]        test_value;
   logic [DATA_WIDTH-1:0]        write_data;
   logic [2:0]                   write_index;
   logic                         write_enable;
   logic signed [JUMP_WIDTH-1:0] jump_sum;

   program_memory #(
      .SIZE       (PROG_MEMORY_SIZE),
      .ADDR_WIDTH (PC_WIDTH)
   ) program_memory_unit (
      .address     (pc),
      .instruction (instruction)
   );

   // Sequential successor and relative jump target, both wrapped into the
   // program memory. A single correction step suffices because the memory is
   // never smaller than the +/-256 reach of a jump offset.
   always_comb begin
      pc_step  = (pc == PC_WIDTH'(PROG_MEMORY_SIZE - 1)) ? '0 : pc + PC_WIDTH'(1);
      jump_sum = signed'(JUMP_WIDTH'(pc)) + JUMP_WIDTH'(signed'(instruction[8:0]));
      if (jump_sum[JUMP_WIDTH-1])
         pc_jump = PC_WIDTH'(jump_sum + JUMP_WIDTH'(PROG_MEMORY_SIZE));
      else if (jump_sum >= JUMP_WIDTH'(PROG_MEMORY_SIZE))
         pc_jump = PC_WIDTH'(jump_sum - JUMP_WIDTH'(PROG_MEMORY_SIZE));
      else
         pc_jump = PC_WIDTH'(jump_sum);
   end

   // Decode and ALU: operands come from the current register state, so a
   // destination may safely alias either source.
   always_comb begin
      opcode       = instruction[15:12];
      operand_a    = registers[instruction[5:3]];
      operand_b    = registers[instruction[2:0]];
      test_value   = registers[instruction[11:9]];
      pc_next      = pc_step;
      halt_now     = 1'b0;
      write_enable = 1'b0;
      write_index  = instruction[8:6];
      write_data   = '0;
      case (opcode)
         architecture::OP_LOADC: begin
            write_enable = 1'b1;
            write_index  = instruction[10:8];
            write_data   = DATA_WIDTH'(instruction[7:0]);
         end
         architecture::OP_ADD: begin
            write_enable = 1'b1;
            write_data   = operand_a + operand_b;
         end
         architecture::OP_SUB: begin
            write_enable = 1'b1;
            write_data   = operand_a - operand_b;
         end
         architecture::OP_AND: begin
            write_enable = 1'b1;
            write_data   = operand_a & operand_b;
         end
         architecture::OP_OR: begin
            write_enable = 1'b1;
            write_data   = operand_a | operand_b;
         end
         architecture::OP_XOR: begin
            write_enable = 1'b1;
            write_data   = operand_a ^ operand_b;
         end
         architecture::OP_JMP: begin
            pc_next = pc_jump;
         end
         architecture::OP_JMPZ: begin
            if (test_value == '0)
               pc_next = pc_jump;
         end
         architecture::OP_HALT: begin
            pc_next  = pc;
            halt_now = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Architectural state update; once halted nothing changes until reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc     <= '0;
         halted <= 1'b0;
         for (int i = 0; i < 8; i++)
            registers[i] <= '0;
      end else if (!halted) begin
         pc     <= pc_next;
         halted <= halt_now;
         if (write_enable)
            registers[write_index] <= write_data;
      end
   end

endmodule

// File: tb/tb_computer.sv
// Bench for the single-cycle computer: an instruction-level reference model
// runs alongside the DUT and is compared every cycle, directed programs pin
// the model with literal results, and random programs exercise the rest.
module tb_computer;
   import architecture::*;

   localparam int MEM = PROG_MEMORY_SIZE;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int n_checks = 0;
   int n_errors = 0;
   bit check_en = 1'b0;

   logic [15:0] m_mem  [0:MEM-1];
   bit   [31:0] m_regs [0:7];
   int          m_pc     = 0;
   bit          m_halted = 1'b0;

   computer #(.PROG_MEMORY_SIZE(MEM), .DATA_WIDTH(32)) dut (
      .clock (clock),
      .reset (reset)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic int wrap_pc(input int x);
      return ((x % MEM) + MEM) % MEM;
   endfunction

   function automatic int offset9(input logic [15:0] w);
      int off;
      off = int'(w[8:0]);
      if (off >= 256) off -= 512;
      return off;
   endfunction

   // Instruction-level model: one architectural instruction per clock.
   task automatic model_step();
      logic [15:0] w;
      bit [31:0]   a;
      bit [31:0]   b;
      int          next_pc;
      w       = m_mem[m_pc];
      a       = m_regs[w[5:3]];
      b       = m_regs[w[2:0]];
      next_pc = wrap_pc(m_pc + 1);
      case (int'(w[15:12]))
         1:  m_regs[w[10:8]] = {24'h0, w[7:0]};
         2:  m_regs[w[8:6]]  = a + b;
         3:  m_regs[w[8:6]]  = a - b;
         4:  m_regs[w[8:6]]  = a & b;
         5:  m_regs[w[8:6]]  = a | b;
         6:  m_regs[w[8:6]]  = a ^ b;
         7:  next_pc = wrap_pc(m_pc + offset9(w));
         8:  if (m_regs[w[11:9]] == 0) next_pc = wrap_pc(m_pc + offset9(w));
         15: begin
            m_halted = 1'b1;
            next_pc  = m_pc;
         end
         default: ;
      endcase
      m_pc = next_pc;
   endtask

   always @(posedge clock) begin
      if (reset) begin
         m_pc     = 0;
         m_halted = 1'b0;
         for (int i = 0; i < 8; i++) m_regs[i] = 0;
      end else if (!m_halted) begin
         model_step();
      end
   end

   // Every-cycle comparison of the architectural state against the model.
   always @(negedge clock) begin
      if (check_en) begin
         check("pc", 64'(dut.pc), 64'(m_pc));
         check("halted", 64'(dut.halted), 64'(m_halted));
         for (int i = 0; i < 8; i++)
            check($sformatf("r%0d", i), 64'(dut.registers[i]), 64'(m_regs[i]));
      end
   end

   task automatic load_word(input int addr, input logic [15:0] w);
      m_mem[addr] = w;
      dut.program_memory_unit.memory[addr] = w;
   endtask

   task automatic fill_halt();
      for (int i = 0; i < MEM; i++) load_word(i, HALT_INST);
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   function automatic logic [15:0] rand_inst();
      int          k;
      logic [11:0] low;
      k   = $urandom_range(0, 99);
      low = 12'($urandom);
      if (k < 2)  return HALT_INST;
      if (k < 30) return {OP_LOADC, low};
      if (k < 70) return {4'($urandom_range(2, 6)), low};
      if (k < 78) return {OP_JMP, low};
      if (k < 90) return {OP_JMPZ, low};
      if (k < 95) return {OP_NOP, low};
      return {4'($urandom_range(9, 14)), low};
   endfunction

   logic [31:0] t1_vals [0:7];

   initial begin
      t1_vals = '{32'hD, 32'hE, 32'hA, 32'hD, 32'hB, 32'hA, 32'hB, 32'hE};

      // Load-constant program ending in NOPs then HALT.
      fill_halt();
      for (int i = 0; i < 8; i++) load_word(i, loadc_inst(3'(i), t1_vals[i][7:0]));
      load_word(8, NOP_INST);
      load_word(9, NOP_INST);
      do_reset();
      check_en = 1'b1;
      check("t1_reset_pc", 64'(dut.pc), 64'd0);
      check("t1_reset_halted", 64'(dut.halted), 64'd0);
      run(30);
      for (int i = 0; i < 8; i++)
         check($sformatf("t1_r%0d", i), 64'(dut.registers[i]), 64'(t1_vals[i]));
      check("t1_halted", 64'(dut.halted), 64'd1);
      check("t1_pc", 64'(dut.pc), 64'd10);

      // Wrapping arithmetic.
      fill_halt();
      load_word(0, loadc_inst(R1, 8'hFF));
      load_word(1, loadc_inst(R2, 8'h01));
      load_word(2, add_inst(R3, R1, R2));
      load_word(3, sub_inst(R4, R2, R1));
      do_reset();
      run(10);
      check("t2_add", 64'(dut.registers[3]), 64'h0000_0100);
      check("t2_sub", 64'(dut.registers[4]), 64'hFFFF_FF02);

      // Taken JMPZ skips a load.
      fill_halt();
      load_word(0, loadc_inst(R0, 8'h00));
      load_word(1, jmpz_inst(R0, 9'd2));
      load_word(2, loadc_inst(R5, 8'h01));
      do_reset();
      run(10);
      check("t3_r5", 64'(dut.registers[5]), 64'd0);
      check("t3_pc", 64'(dut.pc), 64'd3);

      // Aliased operands, logic ops, undefined opcode, untaken JMPZ.
      fill_halt();
      load_word(0, loadc_inst(R1, 8'h05));
      load_word(1, add_inst(R1, R1, R1));
      load_word(2, loadc_inst(R2, 8'h0C));
      load_word(3, and_inst(R3, R1, R2));
      load_word(4, or_inst(R4, R1, R2));
      load_word(5, xor_inst(R5, R1, R2));
      load_word(6, 16'h9ABC);
      load_word(7, jmpz_inst(R1, 9'd5));
      do_reset();
      run(12);
      check("t4_alias_add", 64'(dut.registers[1]), 64'hA);
      check("t4_and", 64'(dut.registers[3]), 64'h8);
      check("t4_or", 64'(dut.registers[4]), 64'hE);
      check("t4_xor", 64'(dut.registers[5]), 64'h6);
      check("t4_pc", 64'(dut.pc), 64'd8);

      // HALT as the first instruction.
      fill_halt();
      do_reset();
      for (int c = 0; c < 20; c++) begin
         run(1);
         check("t5_pc", 64'(dut.pc), 64'd0);
      end
      for (int i = 0; i < 8; i++)
         check($sformatf("t5_r%0d", i), 64'(dut.registers[i]), 64'd0);
      check("t5_halted", 64'(dut.halted), 64'd1);

      // Reset mid-program restarts from word 0.
      fill_halt();
      for (int i = 0; i < 8; i++) load_word(i, loadc_inst(3'(i), t1_vals[i][7:0]));
      load_word(8, NOP_INST);
      load_word(9, NOP_INST);
      do_reset();
      run(4);
      check("t6_mid_r3", 64'(dut.registers[3]), 64'hD);
      do_reset();
      check("t6_rst_pc", 64'(dut.pc), 64'd0);
      check("t6_rst_r0", 64'(dut.registers[0]), 64'd0);
      check("t6_rst_r4", 64'(dut.registers[4]), 64'd0);
      run(30);
      check("t6_r7", 64'(dut.registers[7]), 64'hE);
      check("t6_pc", 64'(dut.pc), 64'd10);

      // Backward jump from word 0 wraps to the last word.
      fill_halt();
      load_word(0, jmp_inst(9'h1FF));
      do_reset();
      run(1);
      check("t7_wrap_pc", 64'(dut.pc), 64'd1023);
      run(1);
      check("t7_halted", 64'(dut.halted), 64'd1);

      // Random programs with occasional reset pulses.
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < MEM; i++) load_word(i, rand_inst());
         do_reset();
         for (int c = 0; c < 200; c++) begin
            @(posedge clock); #1;
            reset = ($urandom_range(0, 99) < 3);
         end
         @(posedge clock); #1;
         reset = 1'b0;
      end

      run(2);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
